// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, receiver FSM states and error-flag bit positions
// for the VGA sync receiver.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int unsigned LOCK_FRAMES = 2;

  localparam int unsigned ERR_LINE_LEN    = 0;
  localparam int unsigned ERR_ACT_WIDTH   = 1;
  localparam int unsigned ERR_FRAME_LINES = 2;
  localparam int unsigned ERR_ACT_LINES   = 3;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } vga_rx_state_t;

  // Counters stick at 1023 instead of wrapping so a malformed stream cannot alias to a legal count.
  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/vga_edge_det.sv
// Falling-edge detector for an active-low sync line, sampled only on pix_en ticks.
// The previous sample is held in a register so the pulse lines up with the current tick.
module vga_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic pix_en,
  input  logic sig_n,
  output logic fall
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = pix_en ? sig_n : prev_q;
    fall   = pix_en & prev_q & ~sig_n;
  end

  // Idle level is high, so reset to 1 to avoid a false assertion on the first sample.
  always_ff @(posedge clk) begin
    if (reset) prev_q <= 1'b1;
    else       prev_q <= prev_d;
  end

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA receive-side decoder: rebuilds pixel x/y from HS/VS, checks timing and reports lock.
// Define VGA_RX_CHECKSUM_EN to add the per-frame R+G+B checksum outputs (frame_sum, sum_valid).
//
// state   | meaning
// SEARCH  | waiting for the first VS assertion
// MEASURE | counting consecutive clean frames toward lock
// LOCKED  | timing verified; pixels are forwarded
module vga_sync_receiver #(
  parameter int unsigned CFG_H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned CFG_H_TOTAL     = vga_timing_pkg::H_TOTAL,
  parameter int unsigned CFG_V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned CFG_V_TOTAL     = vga_timing_pkg::V_TOTAL,
  parameter int unsigned CFG_LOCK_FRAMES = vga_timing_pkg::LOCK_FRAMES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        vga_hs_n,
  input  logic        vga_vs_n,
  input  logic        vga_blank_n,
  input  logic [23:0] vga_rgb,
  input  logic        err_clear,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [23:0] pix_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic [3:0]  err_flags
`ifdef VGA_RX_CHECKSUM_EN
  ,
  output logic [31:0] frame_sum,
  output logic        sum_valid
`endif
);

  import vga_timing_pkg::*;

  localparam logic [9:0] H_ACT_L = CFG_H_ACTIVE[9:0];
  localparam logic [9:0] H_TOT_L = CFG_H_TOTAL[9:0];
  localparam logic [9:0] V_ACT_L = CFG_V_ACTIVE[9:0];
  localparam logic [9:0] V_TOT_L = CFG_V_TOTAL[9:0];
  localparam logic [2:0] LOCK_L  = CFG_LOCK_FRAMES[2:0];

  logic hs_fall, vs_fall;

  vga_edge_det u_hs_det (.clk(clk), .reset(reset), .pix_en(pix_en), .sig_n(vga_hs_n), .fall(hs_fall));
  vga_edge_det u_vs_det (.clk(clk), .reset(reset), .pix_en(pix_en), .sig_n(vga_vs_n), .fall(vs_fall));

  vga_rx_state_t state_q, state_d;
  logic [9:0]  h_cnt_q, h_cnt_d, x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d, line_cnt_q, line_cnt_d;
  logic        h_seen_q, h_seen_d, v_seen_q, v_seen_d;
  logic [2:0]  clean_q, clean_d;
  logic [3:0]  err_q, err_d, evt;
  logic        pix_valid_q, pix_valid_d, frame_start_q, frame_start_d, locked_q, locked_d;
  logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [23:0] pix_rgb_q, pix_rgb_d;
  logic        line_active, locked_now;
  logic [10:0] act_lines;

  always_comb begin
    h_cnt_d    = h_cnt_q;
    x_cnt_d    = x_cnt_q;
    y_cnt_d    = y_cnt_q;
    line_cnt_d = line_cnt_q;
    h_seen_d   = h_seen_q;
    v_seen_d   = v_seen_q;
    evt        = 4'b0;
    line_active = (x_cnt_q != 10'd0);
    // The line that ends on this sample still counts when HS and VS assert together.
    act_lines  = {1'b0, y_cnt_q} + {10'b0, hs_fall & line_active};

    if (pix_en) begin
      if (hs_fall) begin
        if (h_seen_q) begin
          evt[ERR_LINE_LEN]  = (h_cnt_q != H_TOT_L);
          evt[ERR_ACT_WIDTH] = line_active && (x_cnt_q != H_ACT_L);
        end
        h_cnt_d  = 10'd1;
        x_cnt_d  = 10'd0;
        h_seen_d = 1'b1;
      end else begin
        h_cnt_d = sat_inc(h_cnt_q);
        if (vga_blank_n) x_cnt_d = sat_inc(x_cnt_q);
      end

      if (vs_fall) begin
        if (v_seen_q) begin
          evt[ERR_FRAME_LINES] = (line_cnt_q != V_TOT_L);
          evt[ERR_ACT_LINES]   = (act_lines != {1'b0, V_ACT_L});
        end
        y_cnt_d    = 10'd0;
        line_cnt_d = 10'd1;
        v_seen_d   = 1'b1;
      end else if (hs_fall) begin
        if (line_active) y_cnt_d = sat_inc(y_cnt_q);
        line_cnt_d = sat_inc(line_cnt_q);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    clean_d = clean_q;
    case (state_q)
      SEARCH: begin
        if (vs_fall && (evt == 4'b0)) begin
          state_d = MEASURE;
          clean_d = 3'd0;
        end
      end
      MEASURE: begin
        if (evt != 4'b0) begin
          state_d = SEARCH;
        end else if (vs_fall) begin
          clean_d = clean_q + 3'd1;
          if (clean_q + 3'd1 == LOCK_L) state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (evt != 4'b0) state_d = SEARCH;
      end
      default: state_d = SEARCH;
    endcase
  end

  always_comb begin
    locked_now    = (state_q == LOCKED);
    pix_valid_d   = locked_now && pix_en && vga_blank_n;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    pix_rgb_d     = pix_rgb_q;
    if (pix_valid_d) begin
      pix_x_d   = x_cnt_q;
      pix_y_d   = y_cnt_q;
      pix_rgb_d = vga_rgb;
    end
    frame_start_d = locked_now && vs_fall;
    locked_d      = (state_d == LOCKED);
    // A new error in the same cycle as err_clear keeps its flag set.
    err_d         = (err_clear ? 4'b0 : err_q) | evt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SEARCH;
      h_cnt_q       <= '0;
      x_cnt_q       <= '0;
      y_cnt_q       <= '0;
      line_cnt_q    <= '0;
      h_seen_q      <= 1'b0;
      v_seen_q      <= 1'b0;
      clean_q       <= '0;
      err_q         <= '0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_rgb_q     <= '0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      x_cnt_q       <= x_cnt_d;
      y_cnt_q       <= y_cnt_d;
      line_cnt_q    <= line_cnt_d;
      h_seen_q      <= h_seen_d;
      v_seen_q      <= v_seen_d;
      clean_q       <= clean_d;
      err_q         <= err_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_rgb_q     <= pix_rgb_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_rgb     = pix_rgb_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign err_flags   = err_q;

`ifdef VGA_RX_CHECKSUM_EN
  logic [31:0] acc_q, acc_d, frame_sum_q, frame_sum_d, px_sum;
  logic        sum_valid_q, sum_valid_d;

  always_comb begin
    px_sum      = {24'b0, vga_rgb[23:16]} + {24'b0, vga_rgb[15:8]} + {24'b0, vga_rgb[7:0]};
    acc_d       = acc_q;
    frame_sum_d = frame_sum_q;
    sum_valid_d = 1'b0;
    if (!locked_now) begin
      acc_d = 32'b0;
    end else if (frame_start_d) begin
      frame_sum_d = acc_q;
      sum_valid_d = 1'b1;
      acc_d       = pix_valid_d ? px_sum : 32'b0;
    end else if (pix_valid_d) begin
      acc_d = acc_q + px_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      frame_sum_q <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      frame_sum_q <= frame_sum_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  assign frame_sum = frame_sum_q;
  assign sum_valid = sum_valid_q;
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Scoreboard bench for vga_sync_receiver on a reduced 8x4 raster (16 ticks/line, 8 lines/frame).
module tb_vga_sync_receiver;

  localparam int HA = 8, HSY = 2, HBP = 2, HT = 16;
  localparam int VA = 4, VSY = 1, VBP = 1, VT = 8;
  localparam int ACT_COL0 = HSY + HBP;
  localparam int ACT_LINE0 = VSY + VBP;

  logic clk = 1'b0;
  logic reset, pix_en, vga_hs_n, vga_vs_n, vga_blank_n, err_clear;
  logic [23:0] vga_rgb;
  logic        pix_valid, frame_start, locked;
  logic [9:0]  pix_x, pix_y;
  logic [23:0] pix_rgb;
  logic [3:0]  err_flags;
`ifdef VGA_RX_CHECKSUM_EN
  logic [31:0] frame_sum;
  logic        sum_valid;
`endif

  always #5 clk = ~clk;

  vga_sync_receiver #(
    .CFG_H_ACTIVE(HA), .CFG_H_TOTAL(HT), .CFG_V_ACTIVE(VA), .CFG_V_TOTAL(VT), .CFG_LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .vga_hs_n(vga_hs_n), .vga_vs_n(vga_vs_n),
    .vga_blank_n(vga_blank_n), .vga_rgb(vga_rgb), .err_clear(err_clear),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .frame_start(frame_start), .locked(locked), .err_flags(err_flags)
`ifdef VGA_RX_CHECKSUM_EN
    , .frame_sum(frame_sum), .sum_valid(sum_valid)
`endif
  );

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] rgb;
  } px_t;

  int n_cmp = 0;
  int n_bad = 0;
  int n_px  = 0;
  int n_fs  = 0;
  int n_sv  = 0;
  px_t exp_q[$];
  logic [31:0] sum_q[$];
  logic [31:0] m_sum;
  logic [31:0] last_sum;
  bit   m_prev_full;
  px_t  mon_e;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (pix_valid) begin
      n_px++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pixel: got (%0d,%0d) required none", pix_x, pix_y);
      end else begin
        mon_e = exp_q.pop_front();
        check("pixel", {20'b0, pix_x, pix_y, pix_rgb}, {20'b0, mon_e});
      end
    end
    if (frame_start) n_fs++;
`ifdef VGA_RX_CHECKSUM_EN
    if (sum_valid) begin
      n_sv++;
      last_sum = frame_sum;
      if (sum_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_sum: got %0d required none", frame_sum);
      end else begin
        check("frame_sum", {32'b0, frame_sum}, {32'b0, sum_q.pop_front()});
      end
    end
`endif
  end

  task automatic tick(input logic hs_n, input logic vs_n, input logic blank_n,
                      input logic [23:0] rgb, input logic clr);
    @(negedge clk);
    vga_hs_n = hs_n; vga_vs_n = vs_n; vga_blank_n = blank_n; vga_rgb = rgb;
    err_clear = clr; pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0; err_clear = 1'b0;
  endtask

  task automatic check_zero(input string name);
    check(name, {13'b0, pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked, err_flags}, 64'b0);
  endtask

  // lock_until: pixels on lines below this index are expected on the output.
  task automatic drive_frame(input int short_line, input int n_act, input int clr_line,
                             input int lock_until, input int rst_line, input bit fixed_rgb,
                             input int fidx);
    int len;
    bit act_line, blank, after_rst;
    logic [23:0] rgb;
    px_t e;
    after_rst = 1'b0;
`ifdef VGA_RX_CHECKSUM_EN
    if (m_prev_full) sum_q.push_back(m_sum);
`endif
    m_sum = 32'd0;
    for (int l = 0; l < VT; l++) begin
      len = (l == short_line) ? HT - 1 : HT;
      act_line = (l >= ACT_LINE0) && (l < ACT_LINE0 + n_act);
      for (int c = 0; c < len; c++) begin
        blank = act_line && (c >= ACT_COL0) && (c < ACT_COL0 + HA);
        rgb = fixed_rgb ? 24'h010203 :
              {8'((c - ACT_COL0) * 3 + fidx), 8'((l - ACT_LINE0) * 7 + 1), 8'(fidx)};
        if (blank && (l < lock_until) && !after_rst) begin
          e.x = 10'(c - ACT_COL0);
          e.y = 10'(l - ACT_LINE0);
          e.rgb = rgb;
          exp_q.push_back(e);
          m_sum += {24'b0, rgb[23:16]} + {24'b0, rgb[15:8]} + {24'b0, rgb[7:0]};
        end
        tick(c >= HSY, l >= VSY, blank, rgb, (l == clr_line) && (c == 0));
        if ((l == rst_line) && (c == ACT_COL0 + 3)) begin
          reset = 1'b1;
          @(negedge clk);
          check_zero("outputs_after_midline_reset");
          reset = 1'b0;
          after_rst = 1'b1;
        end
      end
    end
    m_prev_full = (lock_until >= VT) && (rst_line < 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pix_en = 1'b0; vga_hs_n = 1'b1; vga_vs_n = 1'b1; vga_blank_n = 1'b0;
    vga_rgb = 24'h0; err_clear = 1'b0; m_prev_full = 1'b0; m_sum = 0; last_sum = 0;
    repeat (3) @(negedge clk);
    check_zero("reset_outputs");
    reset = 1'b0;

    drive_frame(-1, VA, -1, 0, -1, 0, 1);
    drive_frame(-1, VA, -1, 0, -1, 0, 2);
    check("locked_after_f2", {63'b0, locked}, 64'd0);
    drive_frame(-1, VA, -1, VT, -1, 0, 3);
    check("locked_in_f3", {63'b0, locked}, 64'd1);
    check("f3_pixel_count", n_px, 32);
    check("f3_queue_drained", exp_q.size(), 0);

    drive_frame(3, VA, -1, 4, -1, 0, 4);
    check("short_line_err", {60'b0, err_flags}, 64'h1);
    check("short_line_unlock", {63'b0, locked}, 64'd0);
    drive_frame(-1, VA, -1, 0, -1, 0, 5);
    drive_frame(-1, VA, -1, 0, -1, 0, 6);
    drive_frame(-1, VA, 5, VT, -1, 0, 7);
    check("relock_after_short", {63'b0, locked}, 64'd1);
    check("err_cleared", {60'b0, err_flags}, 64'h0);
    drive_frame(-1, VA, -1, VT, -1, 0, 8);
    check("err_stays_clear", {60'b0, err_flags}, 64'h0);
    drive_frame(3, VA, 4, 4, -1, 0, 9);
    check("clear_vs_error", {60'b0, err_flags}, 64'h1);
    check("unlock_f9", {63'b0, locked}, 64'd0);

    drive_frame(-1, VA, -1, 0, -1, 0, 10);
    drive_frame(-1, VA, -1, 0, -1, 0, 11);
    drive_frame(-1, VA, 5, VT, -1, 0, 12);
    check("err_clear_f12", {60'b0, err_flags}, 64'h0);
    drive_frame(-1, VA - 1, -1, VT, -1, 0, 13);
    drive_frame(-1, VA, -1, 0, -1, 0, 14);
    check("active_lines_err", {60'b0, err_flags}, 64'h8);
    check("active_lines_unlock", {63'b0, locked}, 64'd0);

    drive_frame(-1, VA, -1, 0, -1, 0, 15);
    drive_frame(-1, VA, -1, 0, -1, 0, 16);
    drive_frame(-1, VA, -1, VT, 3, 0, 17);
    drive_frame(-1, VA, -1, 0, -1, 0, 18);
    drive_frame(-1, VA, -1, 0, -1, 0, 19);
    check("no_lock_f19", {63'b0, locked}, 64'd0);
    drive_frame(-1, VA, -1, VT, -1, 1, 20);
    drive_frame(-1, VA, -1, VT, -1, 0, 21);
    repeat (2) @(negedge clk);

    check("final_locked", {63'b0, locked}, 64'd1);
    check("final_err", {60'b0, err_flags}, 64'h0);
    check("frame_start_count", n_fs, 6);
    check("total_pixels", n_px, 260);
    check("pixel_queue_drained", exp_q.size(), 0);
`ifdef VGA_RX_CHECKSUM_EN
    check("sum_valid_count", n_sv, 6);
    check("checksum_f20", {32'b0, last_sum}, 64'd192);
    check("sum_queue_drained", sum_q.size(), 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
